// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/stall controller
package hazard_pkg;

  // MDU countdown FSM encoding
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Operand not read by the D-stage instruction
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Default MDU occupancy after issue
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - pipeline-side signal bundle of the hazard/stall controller (STALL_STAT_EN adds stall_cnt)
interface hazard_stall_ctrl_if;

  logic [4:0]  rs_D;
  logic [4:0]  rt_D;
  logic [1:0]  tuse_rs_D;
  logic [1:0]  tuse_rt_D;
  logic        md_use_D;
  logic [4:0]  wa_E;
  logic [1:0]  tnew_E;
  logic [4:0]  wa_M;
  logic [1:0]  tnew_M;
  logic        md_start_E;
  logic        md_div_E;
  logic        stall;
  logic        pc_en;
  logic        flush_E;
  logic        md_busy;
`ifdef STALL_STAT_EN
  logic [31:0] stall_cnt;

  // Pipeline side: presents stage operands, consumes stall controls
  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
    output wa_E, tnew_E, wa_M, tnew_M, md_start_E, md_div_E,
    input  stall, pc_en, flush_E, md_busy, stall_cnt
  );

  // Controller side
  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
    input  wa_E, tnew_E, wa_M, tnew_M, md_start_E, md_div_E,
    output stall, pc_en, flush_E, md_busy, stall_cnt
  );
`else
  // Pipeline side: presents stage operands, consumes stall controls
  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
    output wa_E, tnew_E, wa_M, tnew_M, md_start_E, md_div_E,
    input  stall, pc_en, flush_E, md_busy
  );

  // Controller side
  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
    input  wa_E, tnew_E, wa_M, tnew_M, md_start_E, md_div_E,
    output stall, pc_en, flush_E, md_busy
  );
`endif

endinterface

// File: rtl/md_busy_tracker.sv
// rtl/md_busy_tracker.sv - multiply/divide unit occupancy countdown
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_E,
  input  logic md_div_E,
  output logic md_busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;

  // Countdown FSM: a new issue always reloads, even over a running operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else if (md_start_E) begin
      state_q <= MD_BUSY;
      cnt_q   <= md_div_E ? DIV_LOAD : MULT_LOAD;
    end else begin
      case (state_q)
        MD_BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= MD_IDLE;
          end
        end
        default: begin
          state_q <= MD_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Busy in the issue cycle itself, then for the loaded number of cycles
  assign md_busy = md_start_E || (cnt_q != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - stall/flush scheduler for the 5-stage pipeline (STALL_STAT_EN adds stall_cnt)
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  bus
);

  logic md_busy_raw;
  logic hz_rs;
  logic hz_rt;
  logic stall_raw;
  logic stall_int;

  md_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_tracker (
    .clk        (clk),
    .reset      (reset),
    .md_start_E (bus.md_start_E),
    .md_div_E   (bus.md_div_E),
    .md_busy    (md_busy_raw)
  );

  // RAW hazards that forwarding cannot cover; $0 never hazards, tuse=3 never loses
  always_comb begin
    hz_rs = (bus.rs_D != 5'd0) &&
            (((bus.rs_D == bus.wa_E) && (bus.tnew_E > bus.tuse_rs_D)) ||
             ((bus.rs_D == bus.wa_M) && (bus.tnew_M > bus.tuse_rs_D)));
    hz_rt = (bus.rt_D != 5'd0) &&
            (((bus.rt_D == bus.wa_E) && (bus.tnew_E > bus.tuse_rt_D)) ||
             ((bus.rt_D == bus.wa_M) && (bus.tnew_M > bus.tuse_rt_D)));
    stall_raw = hz_rs || hz_rt || (bus.md_use_D && md_busy_raw);
  end

  // Reset forces a free-running pipeline regardless of the hazard inputs
  assign stall_int   = stall_raw && !reset;
  assign bus.stall   = stall_int;
  assign bus.pc_en   = !stall_int;
  assign bus.flush_E = stall_int;
  assign bus.md_busy = md_busy_raw && !reset;

`ifdef STALL_STAT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Saturating count of stalled cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_int && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Statistics register
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl (STALL_STAT_EN checks stall_cnt)
module tb_hazard_stall_ctrl;

  localparam int MULT = 5;
  localparam int DIV  = 10;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tu_rs;
    logic [1:0] tu_rt;
    logic       md_use;
    logic [4:0] wa_e;
    logic [1:0] tn_e;
    logic [4:0] wa_m;
    logic [1:0] tn_m;
    logic       start;
    logic       div;
  } stim_t;

  typedef struct {
    int          cyc;
    logic        stall;
    logic        pc_en;
    logic        flush_E;
    logic        md_busy;
    logic [31:0] stall_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if bus ();

  hazard_stall_ctrl #(
    .MULT_CYCLES (MULT),
    .DIV_CYCLES  (DIV),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: cycle index, last cycle the MDU is still busy, stall tally
  int      cycle    = 0;
  int      busy_end = -1;
  longint  stat     = 0;
  logic    p_valid  = 1'b0;
  stim_t   p_s;
  logic    p_stall;

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  function automatic logic ref_hz(input int src, input int tuse, input int wa_e, input int tn_e,
                                  input int wa_m, input int tn_m);
    if (src == 0) return 1'b0;
    return ((src == wa_e) && (tn_e > tuse)) || ((src == wa_m) && (tn_m > tuse));
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s.rst = 1'b0; s.rs = 5'd0; s.rt = 5'd0; s.tu_rs = 2'd3; s.tu_rt = 2'd3;
    s.md_use = 1'b0; s.wa_e = 5'd0; s.tn_e = 2'd0; s.wa_m = 5'd0; s.tn_m = 2'd0;
    s.start = 1'b0; s.div = 1'b0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst    = ($urandom_range(0, 39) == 0);
    s.rs     = 5'($urandom_range(0, 3));
    s.rt     = 5'($urandom_range(0, 3));
    s.tu_rs  = 2'($urandom_range(0, 3));
    s.tu_rt  = 2'($urandom_range(0, 3));
    s.md_use = 1'($urandom_range(0, 1));
    s.wa_e   = 5'($urandom_range(0, 3));
    s.tn_e   = 2'($urandom_range(0, 2));
    s.wa_m   = 5'($urandom_range(0, 3));
    s.tn_m   = 2'($urandom_range(0, 1));
    s.start  = ($urandom_range(0, 7) == 0);
    s.div    = 1'($urandom_range(0, 1));
    return s;
  endfunction

  // One cycle: retire the previous cycle into the model, drive, push expectation
  task automatic step(input stim_t s);
    exp_t e;
    logic busy, hz;
    @(posedge clk);
    if (p_valid) begin
      if (p_s.rst) begin
        busy_end = -1;
        stat     = 0;
      end else begin
        if (p_s.start) busy_end = cycle + (p_s.div ? DIV : MULT);
        if (p_stall && stat < 64'hFFFF_FFFF) stat++;
      end
      cycle++;
    end
    #1;
    reset          = s.rst;
    bus.rs_D       = s.rs;
    bus.rt_D       = s.rt;
    bus.tuse_rs_D  = s.tu_rs;
    bus.tuse_rt_D  = s.tu_rt;
    bus.md_use_D   = s.md_use;
    bus.wa_E       = s.wa_e;
    bus.tnew_E     = s.tn_e;
    bus.wa_M       = s.wa_m;
    bus.tnew_M     = s.tn_m;
    bus.md_start_E = s.start;
    bus.md_div_E   = s.div;
    busy = !s.rst && (s.start || (cycle <= busy_end));
    hz   = ref_hz(int'(s.rs), int'(s.tu_rs), int'(s.wa_e), int'(s.tn_e), int'(s.wa_m), int'(s.tn_m)) ||
           ref_hz(int'(s.rt), int'(s.tu_rt), int'(s.wa_e), int'(s.tn_e), int'(s.wa_m), int'(s.tn_m));
    e.cyc       = cycle;
    e.stall     = !s.rst && (hz || (s.md_use && busy));
    e.pc_en     = !e.stall;
    e.flush_E   = e.stall;
    e.md_busy   = busy;
    e.stall_cnt = 32'(stat);
    exp_q.push_back(e);
    p_s     = s;
    p_stall = e.stall;
    p_valid = 1'b1;
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("stall",   mon_e.cyc, 32'(bus.stall),   32'(mon_e.stall));
      chk("pc_en",   mon_e.cyc, 32'(bus.pc_en),   32'(mon_e.pc_en));
      chk("flush_E", mon_e.cyc, 32'(bus.flush_E), 32'(mon_e.flush_E));
      chk("md_busy", mon_e.cyc, 32'(bus.md_busy), 32'(mon_e.md_busy));
`ifdef STALL_STAT_EN
      chk("stall_cnt", mon_e.cyc, bus.stall_cnt, mon_e.stall_cnt);
`endif
    end
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    s = idle_stim();
    s.rst = 1'b1;
    step(s); step(s);

    // Load-use: lw $8 in E then in M, consumer in D
    s = idle_stim(); s.wa_e = 5'd8; s.tn_e = 2'd2; s.rs = 5'd8; s.tu_rs = 2'd1;
    step(s);
    s = idle_stim(); s.wa_m = 5'd8; s.tn_m = 2'd1; s.rs = 5'd8; s.tu_rs = 2'd0;
    step(s);
    s = idle_stim(); s.rs = 5'd8; s.tu_rs = 2'd1;
    step(s);

    // Forwardable and $0 cases, rt side too
    s = idle_stim(); s.wa_e = 5'd8; s.tn_e = 2'd1; s.rs = 5'd8; s.tu_rs = 2'd1;
    step(s);
    s = idle_stim(); s.wa_e = 5'd0; s.tn_e = 2'd2; s.tu_rs = 2'd0; s.tu_rt = 2'd0;
    step(s);
    s = idle_stim(); s.wa_m = 5'd9; s.tn_m = 2'd1; s.rt = 5'd9; s.tu_rt = 2'd0;
    step(s);

    // Mult then mflo held in D
    s = idle_stim(); s.start = 1'b1; s.md_use = 1'b1;
    step(s);
    s.start = 1'b0;
    for (int i = 0; i < 8; i++) step(s);

    // Div, D alternates between MDU and non-MDU instructions
    s = idle_stim(); s.start = 1'b1; s.div = 1'b1; s.md_use = 1'b1;
    step(s);
    s.start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      s.md_use = i[0];
      step(s);
    end

    // Reload while busy: mult over a running div
    s = idle_stim(); s.start = 1'b1; s.div = 1'b1; s.md_use = 1'b1;
    step(s);
    s.start = 1'b0; step(s); step(s);
    s.start = 1'b1; s.div = 1'b0; step(s);
    s.start = 1'b0;
    for (int i = 0; i < 8; i++) step(s);

    // Reset mid-countdown with a live hazard on the inputs
    s = idle_stim(); s.start = 1'b1; s.div = 1'b1; s.md_use = 1'b1;
    step(s);
    s.start = 1'b0;
    for (int i = 0; i < 3; i++) step(s);
    s.rst = 1'b1; s.wa_e = 5'd5; s.tn_e = 2'd2; s.rs = 5'd5; s.tu_rs = 2'd0;
    step(s); step(s);
    s = idle_stim(); s.md_use = 1'b1;
    for (int i = 0; i < 4; i++) step(s);

    // Statistics: 6-cycle mult stall then 2-cycle load-use stall
    s = idle_stim(); s.rst = 1'b1;
    step(s);
    s = idle_stim(); s.start = 1'b1; s.md_use = 1'b1;
    step(s);
    s.start = 1'b0;
    for (int i = 0; i < 5; i++) step(s);
    s = idle_stim(); s.wa_e = 5'd8; s.tn_e = 2'd2; s.rs = 5'd8; s.tu_rs = 2'd1;
    step(s);
    s = idle_stim(); s.wa_m = 5'd8; s.tn_m = 2'd1; s.rs = 5'd8; s.tu_rs = 2'd0;
    step(s);
    s = idle_stim();
    step(s);
`ifdef STALL_STAT_EN
    @(negedge clk); #1;
    chk("stall_cnt_plan", cycle, bus.stall_cnt, 32'd8);
`endif
    s = idle_stim(); s.rst = 1'b1;
    step(s);
    s = idle_stim();
    step(s);

    // Randomized traffic
    for (int i = 0; i < 600; i++) step(rand_stim());

    step(idle_stim());
    @(negedge clk); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
